// File: rtl/hlu_seq_pkg.sv
// hlu_pkg: shared HLU control codes, sequencer state encoding and default latencies.
package hlu_pkg;
   localparam logic [3:0] HLU_NONE = 4'b0000;
   localparam logic [3:0] HLU_MULT = 4'b0001;
   localparam logic [3:0] HLU_DIV  = 4'b0010;
   localparam logic [3:0] HLU_MADD = 4'b0011;
   localparam logic [3:0] HLU_MSUB = 4'b0100;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/hlu_seq_if.sv
// hlu_seq_if: EX-stage control/operand bundle into the HI/LO sequencer and its busy/HI/LO outputs.
interface hlu_seq_if;
   logic        start;
   logic [3:0]  hlu_ctrl;
   logic        hlu_unsigned;
   logic        hlu_write;
   logic        hlu_dst;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        cancel;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output start, hlu_ctrl, hlu_unsigned, hlu_write, hlu_dst, rs_val, rt_val, cancel,
                   input busy, hi, lo);
   modport slave  (input start, hlu_ctrl, hlu_unsigned, hlu_write, hlu_dst, rs_val, rt_val, cancel,
                   output busy, hi, lo);
endinterface

// File: rtl/hlu_seq.sv
// hlu_seq: fixed-latency HI/LO sequencer for mult/div and mthi/mtlo.
// Define HLU_MADD_EN to accept madd/msub accumulate codes.
module hlu_seq
   import hlu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic      clk,
   input logic      reset,
   hlu_seq_if.slave bus
);
   logic [0:0]  state;
   logic [3:0]  cnt;
   logic [31:0] hi, lo, a, b, ua, ub, uq, ur, q, r;
   logic [63:0] pend, prod, nxt;
   logic        us, neg_a, neg_b, is_mul, is_div, is_acc, go, wr;
   assign a      = bus.rs_val;
   assign b      = bus.rt_val;
   assign us     = bus.hlu_unsigned;
   assign neg_a  = ~us & a[31];
   assign neg_b  = ~us & b[31];
   // Sign-extending to 64 bits makes the truncated product correct for both signednesses.
   assign prod   = {{32{neg_a}}, a} * {{32{neg_b}}, b};
   assign ua     = neg_a ? -a : a;
   assign ub     = neg_b ? -b : b;
   assign uq     = ua / ub;
   assign ur     = ua % ub;
   assign q      = (neg_a ^ neg_b) ? -uq : uq;
   assign r      = neg_a ? -ur : ur;
   assign is_mul = bus.hlu_ctrl == HLU_MULT;
   assign is_div = bus.hlu_ctrl == HLU_DIV;
`ifdef HLU_MADD_EN
   assign is_acc = (bus.hlu_ctrl == HLU_MADD) || (bus.hlu_ctrl == HLU_MSUB);
   assign nxt    = is_div ? (b == '0 ? {hi, lo} : {r, q}) :
                   is_acc ? (bus.hlu_ctrl == HLU_MSUB ? {hi, lo} - prod : {hi, lo} + prod) : prod;
`else
   assign is_acc = 1'b0;
   assign nxt    = is_div ? (b == '0 ? {hi, lo} : {r, q}) : prod;
`endif
   assign go     = bus.start & ~bus.cancel & (state == IDLE) & (is_mul | is_div | is_acc);
   assign wr     = bus.hlu_write & ~bus.cancel & ~bus.start & (state == IDLE);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (state == RUN) begin
         if (cnt == '0) begin
            state    <= IDLE;
            {hi, lo} <= pend;
         end else
            cnt <= cnt - 4'd1;
      end else if (go) begin
         state <= RUN;
         pend  <= nxt;
         cnt   <= is_div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
      end else if (wr) begin
         if (bus.hlu_dst) hi <= a;
         else lo <= a;
      end
   assign bus.busy = state == RUN;
   assign bus.hi   = hi;
   assign bus.lo   = lo;
   // The hazard unit must hold new HLU instructions in D while an operation runs.
   a_no_issue_busy: assert property (@(posedge clk) disable iff (reset)
      state == RUN |-> !(bus.start || bus.hlu_write));
endmodule

// File: tb/tb_hlu_seq.sv
// tb_hlu_seq: randomized and directed bench for hlu_seq against an arithmetic reference model.
module tb_hlu_seq;
   import hlu_pkg::*;
   logic clk = 0;
   logic reset = 1;
   int vectors = 0;
   int miscompares = 0;
   logic [31:0] m_hi = 0, m_lo = 0;
   logic [63:0] m_pend = 0;
   int m_left = 0;
   int n;
   hlu_seq_if bus();
   hlu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [63:0] mul64(logic [31:0] a, logic [31:0] b, logic us);
      int ia = a;
      int ib = b;
      longint la = ia;
      longint lb = ib;
      longint unsigned xa = a;
      longint unsigned xb = b;
      return us ? 64'(xa * xb) : 64'(la * lb);
   endfunction

   function automatic logic [63:0] div64(logic [31:0] a, logic [31:0] b, logic us,
                                         logic [31:0] h, logic [31:0] l);
      int ia = a;
      int ib = b;
      int iq, ir;
      if (b == 0) return {h, l};
      if (us) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      iq = ia / ib;
      ir = ia % ib;
      return {ir, iq};
   endfunction

   function automatic bit valid_op(logic [3:0] c);
`ifdef HLU_MADD_EN
      return c == HLU_MULT || c == HLU_DIV || c == HLU_MADD || c == HLU_MSUB;
`else
      return c == HLU_MULT || c == HLU_DIV;
`endif
   endfunction

   always @(posedge clk or posedge reset)
      if (reset) begin
         m_hi = 0;
         m_lo = 0;
         m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) {m_hi, m_lo} = m_pend;
      end else if (bus.start && !bus.cancel && valid_op(bus.hlu_ctrl)) begin
         if (bus.hlu_ctrl == HLU_DIV)
            m_pend = div64(bus.rs_val, bus.rt_val, bus.hlu_unsigned, m_hi, m_lo);
         else if (bus.hlu_ctrl == HLU_MADD)
            m_pend = {m_hi, m_lo} + mul64(bus.rs_val, bus.rt_val, bus.hlu_unsigned);
         else if (bus.hlu_ctrl == HLU_MSUB)
            m_pend = {m_hi, m_lo} - mul64(bus.rs_val, bus.rt_val, bus.hlu_unsigned);
         else
            m_pend = mul64(bus.rs_val, bus.rt_val, bus.hlu_unsigned);
         m_left = bus.hlu_ctrl == HLU_DIV ? 10 : 5;
      end else if (bus.hlu_write && !bus.cancel) begin
         if (bus.hlu_dst) m_hi = bus.rs_val;
         else m_lo = bus.rs_val;
      end

   always @(negedge clk)
      if (!reset) begin
         vectors++;
         if ({bus.busy, bus.hi, bus.lo} !== {m_left > 0, m_hi, m_lo}) begin
            miscompares++;
            $display("FAIL model t=%0t: got busy=%b hi=%h lo=%h, want busy=%b hi=%h lo=%h",
                     $time, bus.busy, bus.hi, bus.lo, m_left > 0, m_hi, m_lo);
         end
      end

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start = 0;
      bus.hlu_ctrl = HLU_NONE;
      bus.hlu_unsigned = 0;
      bus.hlu_write = 0;
      bus.hlu_dst = 0;
      bus.rs_val = 0;
      bus.rt_val = 0;
      bus.cancel = 0;
   endtask

   task automatic issue(logic [3:0] c, logic us, logic [31:0] a, logic [31:0] b, logic cn,
                        output int cycles);
      bus.start = 1;
      bus.hlu_ctrl = c;
      bus.hlu_unsigned = us;
      bus.rs_val = a;
      bus.rt_val = b;
      bus.cancel = cn;
      @(negedge clk);
      idle_inputs();
      cycles = 0;
      while (bus.busy && cycles < 40) begin
         cycles++;
         @(negedge clk);
      end
      if (cycles >= 40) begin
         vectors++;
         miscompares++;
         $display("FAIL busy timeout: got busy after %0d cycles, want low", cycles);
      end
   endtask

   task automatic mt(logic dst, logic [31:0] v, logic cn);
      bus.hlu_write = 1;
      bus.hlu_dst = dst;
      bus.rs_val = v;
      bus.cancel = cn;
      @(negedge clk);
      idle_inputs();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      repeat (2) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset hi", bus.hi, 32'h0);
      check("reset lo", bus.lo, 32'h0);
      reset = 0;
      @(negedge clk);
      issue(HLU_MULT, 0, 32'hFFFF_FFFE, 32'd3, 0, n);
      check("mult cycles", 32'(n), 32'd5);
      check("mult hi", bus.hi, 32'hFFFF_FFFF);
      check("mult lo", bus.lo, 32'hFFFF_FFFA);
      issue(HLU_MULT, 1, 32'hFFFF_FFFE, 32'd3, 0, n);
      check("multu hi", bus.hi, 32'h0000_0002);
      check("multu lo", bus.lo, 32'hFFFF_FFFA);
      issue(HLU_DIV, 0, 32'hFFFF_FFF9, 32'd2, 0, n);
      check("div cycles", 32'(n), 32'd10);
      check("div lo", bus.lo, 32'hFFFF_FFFD);
      check("div hi", bus.hi, 32'hFFFF_FFFF);
      issue(HLU_DIV, 1, 32'd100, 32'd0, 0, n);
      check("divu0 cycles", 32'(n), 32'd10);
      check("divu0 hi", bus.hi, 32'hFFFF_FFFF);
      check("divu0 lo", bus.lo, 32'hFFFF_FFFD);
      issue(HLU_DIV, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
      check("div ovf lo", bus.lo, 32'h8000_0000);
      check("div ovf hi", bus.hi, 32'h0);
      mt(1, 32'h1234_5678, 0);
      check("mthi hi", bus.hi, 32'h1234_5678);
      check("mthi lo", bus.lo, 32'h8000_0000);
      mt(0, 32'hDEAD_BEEF, 1);
      check("mtlo cancel lo", bus.lo, 32'h8000_0000);
      issue(HLU_MULT, 0, 32'd9, 32'd9, 1, n);
      check("cancel start cycles", 32'(n), 32'd0);
      check("cancel start hi", bus.hi, 32'h1234_5678);
      check("cancel start lo", bus.lo, 32'h8000_0000);
`ifdef HLU_MADD_EN
      mt(1, 32'h0, 0);
      mt(0, 32'hFFFF_FFFF, 0);
      issue(HLU_MADD, 0, 32'd1, 32'd1, 0, n);
      check("madd cycles", 32'(n), 32'd5);
      check("madd hi", bus.hi, 32'h1);
      check("madd lo", bus.lo, 32'h0);
      mt(1, 32'h0, 0);
      mt(0, 32'h0, 0);
      issue(HLU_MSUB, 0, 32'd2, 32'd1, 0, n);
      check("msub hi", bus.hi, 32'hFFFF_FFFF);
      check("msub lo", bus.lo, 32'hFFFF_FFFE);
`endif
      bus.start = 1;
      bus.hlu_ctrl = HLU_DIV;
      bus.rs_val = 32'd50;
      bus.rt_val = 32'd7;
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      #2 reset = 1;
      #1;
      check("async reset busy", 32'(bus.busy), 32'h0);
      check("async reset hi", bus.hi, 32'h0);
      check("async reset lo", bus.lo, 32'h0);
      @(posedge clk);
      #2 reset = 0;
      @(negedge clk);
      issue(HLU_MULT, 1, 32'd7, 32'd6, 0, n);
      check("post reset cycles", 32'(n), 32'd5);
      check("post reset lo", bus.lo, 32'd42);
      check("post reset hi", bus.hi, 32'h0);
      repeat (300) begin
         int k;
         k = $urandom_range(0, 9);
         if (k < 6)
            issue(4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), pick(), pick(),
                  $urandom_range(0, 7) == 0, n);
         else if (k < 8)
            mt(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5) == 0);
         else
            @(negedge clk);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hlu_seq.md
Name: hlu_seq

Overview:
- Multi-cycle HI/LO unit sequencer in the EX stage.
- Accepts mult/multu/div/divu starts and mthi/mtlo writes from the decoded control fields.
- Models fixed-latency busy periods and commits results to HI/LO.
- Exports busy/start for the hazard unit's mfhi/mflo/mult stall logic, and honours a cancel input so instructions squashed by an exception never alter HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub when enabled); legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX-stage instruction is a valid HLU arithmetic op this cycle
- hlu_ctrl  input  4  0001 mult, 0010 div, 0011 madd, 0100 msub, others no-op
- hlu_unsigned  input  1  unsigned variant (multu/divu/maddu/msubu)
- hlu_write  input  1  mthi/mtlo this cycle
- hlu_dst  input  1  write target: 1=HI, 0=LO
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- cancel  input  1  EX instruction squashed (exception/eret flush); suppresses start and hlu_write
- busy  output  1  operation in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (async, any state): state IDLE, counter 0, busy 0, hi 0, lo 0, pending result 0.
- States: IDLE, RUN.
- IDLE -> RUN on (start & ~cancel & hlu_ctrl in {mult,div}).
  - Operands are latched at that edge.
  - Result is computed into a pending {p_hi,p_lo} register at the same edge.
  - Counter loads N-1, where N = MULT_CYCLES or DIV_CYCLES.
- RUN:
  - busy = 1.
  - Counter decrements each cycle.
  - When counter == 0, {hi,lo} <= pending at that edge and state -> IDLE.
- Busy timing: busy is high for exactly N cycles, starting the cycle after start. hi/lo show the new value in the first cycle busy is low.
- Stall rule for the hazard unit: stall on (start | busy) for any HLU instruction in D.
- start or hlu_write while RUN: ignored. The pipeline guarantees this does not happen; an assertion flags it.
- hlu_write & ~cancel in IDLE: the selected register <= rs_val at the next edge with no latency. The other register is unchanged.
- start and hlu_write in the same cycle: illegal; start wins.
- Arithmetic:
  - Mult: {hi,lo} = 64-bit product, signed or unsigned per hlu_unsigned.
  - Div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (rs = dividend).
  - Signed 0x80000000 / -1: lo = 0x80000000, hi = 0.
  - Divide by zero: the full busy period still elapses; hi/lo unchanged at commit.
- cancel in the same cycle as start: no state change, busy stays 0.
- cancel while RUN: no effect. The issuing instruction has already committed past EX.
- Unrecognised hlu_ctrl codes with start asserted: no-op.

Optional Feature:
- Macro: HLU_MADD_EN
- Defined:
  - hlu_ctrl 0011 (madd) and 0100 (msub) are accepted.
  - Pending result = {hi,lo} ± product (signed or unsigned), with 64-bit wrap.
  - The accumulate reads HI/LO at the start edge.
  - Latency is MULT_CYCLES.
- Undefined: codes 0011 and 0100 are treated as no-ops; no accumulate logic is synthesised.

Decomposition:
- Shared package hlu_pkg holds:
  - the 4-bit hlu_ctrl codes HLU_NONE, HLU_MULT, HLU_DIV, HLU_MADD, HLU_MSUB
  - the state encoding IDLE/RUN
  - default latency constants
- The decoder and this block both import the codes.
- Single module. Arithmetic is inline combinational; no sub-module is warranted.

Test Plan:
- mult, rs=0xFFFFFFFE, rt=3, signed -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- div, rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with rt=0 -> busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged. mtlo with cancel=1 -> lo unchanged.
- start=1 (mult) with cancel=1 -> busy never rises, hi/lo unchanged.
- reset asserted at cycle 3 of a div, asynchronously mid-cycle -> busy, hi, lo are 0 immediately; after reset, a new mult completes normally.
- HLU_MADD_EN: hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0 after 5 cycles. msub 2*1 from hi=0, lo=0 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
